// File: rtl/eq_mix_pkg.sv
// Shared definitions for the 3-band equalizer recombiner.
// Sample width, FSM state encoding, saturation bounds and sign-extend/clamp helpers.
// Sums are carried at DW+2 bits so three full-scale bands cannot wrap.
package eq_mix_pkg;

    localparam int DW = 23;
    localparam int SW = DW + 2;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_SUM  = 2'd1,
        ST_OUT  = 2'd2
    } mix_state_t;

    localparam logic signed [SW-1:0] SAT_MAX = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {3'b111, {(DW-1){1'b0}}};

    function automatic logic signed [SW-1:0] sext(input logic [DW-1:0] x);
        return {{2{x[DW-1]}}, x};
    endfunction

    function automatic logic over_range(input logic signed [SW-1:0] s);
        return (s > SAT_MAX) || (s < SAT_MIN);
    endfunction

    function automatic logic [DW-1:0] saturate(input logic signed [SW-1:0] s);
        if (s > SAT_MAX)
            return SAT_MAX[DW-1:0];
        else if (s < SAT_MIN)
            return SAT_MIN[DW-1:0];
        else
            return s[DW-1:0];
    endfunction

endpackage

// File: rtl/eq_band_capture.sv
// Per-band capture: rising-edge detect on the ready strobe, sample register and have flag.
// Capture is visible one edge after the strobe rises; cap is combinational for the FSM.
// No backpressure: a new rising edge always overwrites; clr restarts the have flag.
module eq_band_capture #(
    parameter int DW = eq_mix_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic [DW-1:0] din,
    input  logic          clr,
    output logic          cap,
    output logic          have,
    output logic [DW-1:0] sample
);

    logic prev;

    // prev resets high so a ready held across reset release is not a new edge
    assign cap = rdy & ~prev;

    // edge history, sample latch and have flag; clr keeps only this cycle's capture
    always_ff @(posedge clk) begin
        if (rst) begin
            prev   <= 1'b1;
            have   <= 1'b0;
            sample <= '0;
        end else begin
            prev <= rdy;
            if (cap)
                sample <= din;
            if (clr)
                have <= cap;
            else if (cap)
                have <= 1'b1;
        end
    end

endmodule

// File: rtl/eq_band_mixer.sv
// Recombines low/mid/high band samples into one saturated mixed sample per frame.
// Latency: 2 edges from the final band capture to the RDYmix pulse (WAIT -> SUM -> OUT).
// No backpressure: output is a one-cycle pulse; late bands are forced to 0 after TIMEOUT.
module eq_band_mixer #(
    parameter int DW      = eq_mix_pkg::DW,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] inLow,
    input  logic          RDYctrllow,
    input  logic [DW-1:0] inMid,
    input  logic          RDYctrlmid,
    input  logic [DW-1:0] inHigh,
    input  logic          RDYctrlhigh,
    output logic [DW-1:0] outMix,
    output logic          RDYmix,
    output logic          satFlag,
    output logic          missFlag,
    output logic          ovrFlag
);

    import eq_mix_pkg::*;

    localparam int          XW   = DW + 2;
    localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);

    logic [2:0]           cap;
    logic [2:0]           have;
    logic [DW-1:0]        smp_low;
    logic [DW-1:0]        smp_mid;
    logic [DW-1:0]        smp_high;
    logic                 clr;
    logic                 all_next;
    logic [DW-1:0]        op_low;
    logic [DW-1:0]        op_mid;
    logic [DW-1:0]        op_high;
    mix_state_t           state;
    logic [15:0]          timer;
    logic                 miss;
    logic signed [XW-1:0] sum_r;

    // SUM hands the have flags over to the next frame
    assign clr      = (state == ST_SUM);
    assign all_next = &(have | cap);

    // a band that never arrived contributes zero
    assign op_low  = have[0] ? smp_low  : '0;
    assign op_mid  = have[1] ? smp_mid  : '0;
    assign op_high = have[2] ? smp_high : '0;

    eq_band_capture #(.DW(DW)) u_low (
        .clk    (clk),
        .rst    (rst),
        .rdy    (RDYctrllow),
        .din    (inLow),
        .clr    (clr),
        .cap    (cap[0]),
        .have   (have[0]),
        .sample (smp_low)
    );

    eq_band_capture #(.DW(DW)) u_mid (
        .clk    (clk),
        .rst    (rst),
        .rdy    (RDYctrlmid),
        .din    (inMid),
        .clr    (clr),
        .cap    (cap[1]),
        .have   (have[1]),
        .sample (smp_mid)
    );

    eq_band_capture #(.DW(DW)) u_high (
        .clk    (clk),
        .rst    (rst),
        .rdy    (RDYctrlhigh),
        .din    (inHigh),
        .clr    (clr),
        .cap    (cap[2]),
        .have   (have[2]),
        .sample (smp_high)
    );

    // frame FSM: collect bands (with timeout), sum, then clamp and emit one pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_WAIT;
            timer    <= '0;
            miss     <= 1'b0;
            sum_r    <= '0;
            outMix   <= '0;
            RDYmix   <= 1'b0;
            satFlag  <= 1'b0;
            missFlag <= 1'b0;
            ovrFlag  <= 1'b0;
        end else begin
            RDYmix   <= 1'b0;
            satFlag  <= 1'b0;
            missFlag <= 1'b0;
            ovrFlag  <= 1'b0;
            case (state)
                ST_WAIT: begin
                    ovrFlag <= |(cap & have);
                    if (all_next) begin
                        state <= ST_SUM;
                    end else if (|have) begin
                        if (timer == TMAX) begin
                            state <= ST_SUM;
                            miss  <= 1'b1;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                end
                ST_SUM: begin
                    sum_r <= sext(op_low) + sext(op_mid) + sext(op_high);
                    timer <= '0;
                    state <= ST_OUT;
                end
                ST_OUT: begin
                    outMix   <= saturate(sum_r);
                    RDYmix   <= 1'b1;
                    satFlag  <= over_range(sum_r);
                    missFlag <= miss;
                    miss     <= 1'b0;
                    state    <= ST_WAIT;
                end
                default: begin
                    state <= ST_WAIT;
                end
            endcase
        end
    end

endmodule

// File: doc/eq_band_mixer.md
Name: eq_band_mixer

Overview:
Band recombiner at the back of the 3-band equalizer. It consumes the per-band outputs of the low, mid and high gain-control stages, each a 23-bit two's-complement sample plus a ready strobe. It waits until all three bands of a frame are present, sums them with saturation, and emits one mixed sample with a one-cycle ready pulse to the output/DAC stage.

Parameters:
DW, 23, sample width (two's complement)
TIMEOUT, 255, WAIT cycles allowed after the first band of a frame arrives before the missing bands are forced to 0 (range 2..65535)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
inLow  in  DW  low-band sample
RDYctrllow  in  1  low-band ready; level may stay high 1–2 cycles
inMid  in  DW  mid-band sample
RDYctrlmid  in  1  mid-band ready
inHigh  in  DW  high-band sample
RDYctrlhigh  in  1  high-band ready
outMix  out  DW  mixed, saturated sample
RDYmix  out  1  one-cycle pulse: outMix valid
satFlag  out  1  qualified by RDYmix: current outMix was clamped
missFlag  out  1  qualified by RDYmix: frame closed by timeout
ovrFlag  out  1  one-cycle pulse: a band was overwritten before its frame closed

Behaviour:
- Single clock; reset is synchronous and active-high on rst. On reset: outMix=0, RDYmix=0, satFlag=0, missFlag=0, ovrFlag=0, band registers=0, have flags=0, timer=0, state=WAIT, prev-RDY registers=1. The prev-RDY value of 1 means a ready held high through reset release is not captured. Reset mid-frame discards the partial frame.
- Capture: a band is captured at edge k when RDY=1 and prev=0 (rising edge). The sample is latched into that band's register and its have flag is set. Holding a level high for 2 cycles yields one capture.
- FSM states: WAIT, SUM, OUT.
- WAIT:
  - If all three have flags are set after this cycle's captures, go to SUM.
  - Timer runs while at least one have flag is set and not all are set. It increments each cycle. When it reaches TIMEOUT-1, go to SUM with miss=1.
  - A capture on a band whose have flag is already set overwrites that band's register and pulses ovrFlag for 1 cycle.
- SUM:
  - Operand per band = have ? reg : 0. Each operand is sign-extended to DW+2 bits; the three are summed into sum_r.
  - have flags are set to this cycle's captures only. These captures belong to the next frame. No ovrFlag is raised.
  - Timer is cleared. Go to OUT.
- OUT:
  - Clamp sum_r to [-2^(DW-1), 2^(DW-1)-1]. For DW=23 that is [-4194304, 4194303].
  - outMix is loaded with the clamped value. RDYmix=1 and satFlag=(clamped) for that cycle. missFlag=miss; miss is then cleared.
  - Captures in OUT set have flags normally. Go to WAIT.
- Latency: the final band is captured at edge k. SUM occurs at k+1. outMix and RDYmix update at edge k+2, so RDYmix is high in the cycle after k+2.
- Back-to-back frames: the next frame may complete in WAIT immediately after OUT. Minimum frame period is 3 cycles.
- outMix holds its value between pulses. RDYmix, satFlag and missFlag deassert in the cycle after the pulse.
- Two or three bands with rising edges in the same cycle are all captured in that cycle.

Decomposition:
- Package eq_mix_pkg holds: DW, state encoding (WAIT/SUM/OUT), SAT_MAX and SAT_MIN constants, and a sign-extend/saturate function.
- One sub-module, eq_band_capture, instantiated three times. It contains the prev-RDY register, rising-edge detect, sample register and have flag, with a clear/keep input from the FSM.

Test Plan:
1. Low=100, mid=-50, high=7 strobed in the same cycle, each RDY high 1 cycle -> outMix=57, RDYmix pulse 3 cycles after the strobe, satFlag=0.
2. Low=2000000, mid=2000000, high=1000000 on staggered cycles with RDY held 2 cycles each -> one frame only, outMix=4194303, satFlag=1. Repeat with -3000000, -3000000, 0 -> outMix=-4194304, satFlag=1.
3. Only low=10 and mid=20 arrive, TIMEOUT=8 -> RDYmix arrives TIMEOUT+2 cycles after the first capture, outMix=30, missFlag=1.
4. Low strobed twice (5, then 9) before mid and high (1, 1) -> ovrFlag pulse on the second low capture, outMix=11.
5. High strobe lands during the SUM cycle of the previous frame -> prior outMix excludes it; the next frame includes it. No ovrFlag.
6. rst asserted in WAIT with two bands captured, RDYctrlhigh held high across reset release -> no capture on release, no RDYmix, all outputs 0 until the next full frame.
